// File: rtl/gobang_pkg.sv
// Shared GoBang definitions: cell colours, the default board size and the
// move-commit FSM state encoding.
package gobang_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P0    = 2'b01;
  localparam logic [1:0] P1    = 2'b10;

  localparam int BOARD_N_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    CHECK  = 3'd2,
    WRITE  = 3'd3,
    ARM    = 3'd4,
    PULSE  = 3'd5,
    REJECT = 3'd6
  } state_t;

endpackage

// File: rtl/move_commit_edge_detect.sv
// Rising-edge detector: one-cycle pulse when the (already synchronised)
// input goes from 0 to 1.
module edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  // Remember the previous sample of the input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_sig_q <= 1'b0;
    else         r_sig_q <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/move_commit.sv
// Move-commit controller: on a placement request it reads the board cell,
// writes the player's colour if the move is legal, then drives the
// change_enable/turn handshake to the player-colour register. Illegal
// requests produce a one-cycle reject and leave board and player untouched.
//
// Handshakes: a request is a rising edge of place seen while IDLE; edges seen
// while busy are dropped. Board reads return data one cycle after rd_addr.
// change_enable rises one cycle before turn and falls with it, so it is
// stable at the turn rising edge.
module move_commit import gobang_pkg::*; #(
  parameter int BOARD_N = BOARD_N_DEFAULT,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              place,
  input  logic [3:0]        x,
  input  logic [3:0]        y,
  input  logic [1:0]        color,
  input  logic              game_over,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              turn,
  output logic              change_enable,
  output logic              busy,
  output logic              reject,
  output logic [7:0]        move_count,
  output logic              board_full,
  output logic [2:0]        dbg_state
);

  // Cell count and board side at the widths they are compared against.
  localparam logic [7:0] CELLS = 8'(BOARD_N * BOARD_N);
  localparam logic [4:0] SIDE  = 5'(BOARD_N);

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic              w_out_of_range;
  logic              w_bad_colour;
  logic              w_refuse;
  logic              w_board_full;

  state_t            r_state;
  logic [3:0]        r_lx;
  logic [3:0]        r_ly;
  logic [1:0]        r_lcol;
  logic [7:0]        r_move_count;

  edge_detect u_edge (
    .clk    (clk),
    .resetn (resetn),
    .i_sig  (place),
    .o_rise (w_req)
  );

  // Linear cell address of the latched cursor: row-major, y*BOARD_N + x.
  assign w_addr = ADDR_W'(r_ly) * ADDR_W'(BOARD_N) + ADDR_W'(r_lx);

  assign w_board_full   = (r_move_count == CELLS);
  assign w_out_of_range = ({1'b0, r_lx} >= SIDE) || ({1'b0, r_ly} >= SIDE);
  assign w_bad_colour   = (r_lcol != P0) && (r_lcol != P1);
  // game_over, board_full and the cell contents are judged in CHECK.
  assign w_refuse       = w_out_of_range || w_bad_colour || game_over ||
                          w_board_full || (rd_data != EMPTY);

  // Request sequencing FSM with the latched request and the move counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_lx         <= 4'd0;
      r_ly         <= 4'd0;
      r_lcol       <= EMPTY;
      r_move_count <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_lx    <= x;
            r_ly    <= y;
            r_lcol  <= color;
            r_state <= READ;
          end
        end
        READ:   r_state <= CHECK;
        CHECK:  r_state <= w_refuse ? REJECT : WRITE;
        WRITE: begin
          if (r_move_count != CELLS) r_move_count <= r_move_count + 8'd1;
          r_state <= ARM;
        end
        ARM:    r_state <= PULSE;
        PULSE:  r_state <= IDLE;
        REJECT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes are pure decodes of the registered state, so they cannot glitch
  // and drop to 0 the instant reset asserts.
  assign wr_en         = (r_state == WRITE);
  assign wr_addr       = (r_state == WRITE) ? w_addr : '0;
  assign wr_data       = (r_state == WRITE) ? r_lcol : EMPTY;
  assign change_enable = (r_state == ARM) || (r_state == PULSE);
  assign turn          = (r_state == PULSE);
  assign reject        = (r_state == REJECT);
  assign busy          = (r_state != IDLE);
  assign rd_addr       = w_addr;
  assign move_count    = r_move_count;
  assign board_full    = w_board_full;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_move_commit.sv
// Bench for move_commit: board RAM model, directed placement requests, an
// event-timeline reference model and a per-cycle comparator.
module tb_move_commit;

  localparam int NT    = 4096;
  localparam int SIDE  = 15;
  localparam int CELLS = SIDE * SIDE;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       place = 1'b0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic [1:0] color = 2'd0;
  logic       game_over = 1'b0;
  logic [7:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [1:0] wr_data;
  logic       turn;
  logic       change_enable;
  logic       busy;
  logic       reject;
  logic [7:0] move_count;
  logic       board_full;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  move_commit #(.BOARD_N(15), .ADDR_W(8)) dut (
    .clk(clk), .resetn(resetn), .place(place), .x(x), .y(y), .color(color),
    .game_over(game_over), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .turn(turn),
    .change_enable(change_enable), .busy(busy), .reject(reject),
    .move_count(move_count), .board_full(board_full), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- board RAM (sync read, sync write) ----------------
  logic [1:0] ram [256];
  logic       ram_clr = 1'b0;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 2'b00;
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    rd_data <= ram[rd_addr];
  end

  // ---------------- reference model ----------------
  // Each accepted request at cycle k schedules its observable events on a
  // timeline: read at k+1, write at k+3, handshake at k+4..k+5, count at k+4.
  int       cyc = 0;
  bit       chk_en = 1'b0;
  int       busy_until = 0;
  int       m_count = 0;
  int       exp_count = 0;
  bit [1:0] mboard [256];

  bit       e_wr   [NT];
  bit [7:0] e_wa   [NT];
  bit [1:0] e_wd   [NT];
  bit       e_ce   [NT];
  bit       e_turn [NT];
  bit       e_busy [NT];
  bit       e_rej  [NT];
  bit       e_rdv  [NT];
  bit [7:0] e_ra   [NT];
  bit       e_cntv [NT];
  bit [7:0] e_cnt  [NT];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_request(int k, int rx, int ry, int rc, bit go);
    int  a;
    bit  ok;
    if (k < busy_until) return;  // dropped while busy
    a  = ry * SIDE + rx;
    ok = (rx < SIDE) && (ry < SIDE) && (rc == 1 || rc == 2) && !go &&
         (m_count < CELLS) && (mboard[a] == 2'b00);
    e_rdv[k+1] = 1'b1;
    e_ra[k+1]  = 8'(a);
    if (ok) begin
      for (int i = 1; i <= 5; i++) e_busy[k+i] = 1'b1;
      e_wr[k+3]   = 1'b1;
      e_wa[k+3]   = 8'(a);
      e_wd[k+3]   = 2'(rc);
      e_ce[k+4]   = 1'b1;
      e_ce[k+5]   = 1'b1;
      e_turn[k+5] = 1'b1;
      m_count++;
      e_cntv[k+4] = 1'b1;
      e_cnt[k+4]  = 8'(m_count);
      mboard[a]   = 2'(rc);
      busy_until  = k + 6;
    end else begin
      for (int i = 1; i <= 3; i++) e_busy[k+i] = 1'b1;
      e_rej[k+3] = 1'b1;
      busy_until = k + 4;
    end
  endfunction

  // Reset in cycle m cancels everything scheduled after it.
  function automatic void model_reset(int m);
    for (int i = m + 1; i < NT; i++) begin
      e_wr[i] = 0; e_wa[i] = 0; e_wd[i] = 0; e_ce[i] = 0; e_turn[i] = 0;
      e_busy[i] = 0; e_rej[i] = 0; e_rdv[i] = 0; e_ra[i] = 0;
      e_cntv[i] = 0; e_cnt[i] = 0;
    end
    m_count    = 0;
    exp_count  = 0;
    busy_until = 0;
  endfunction

  // ---------------- per-cycle comparator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (chk_en && cyc < NT) begin
        if (e_cntv[cyc]) exp_count = int'(e_cnt[cyc]);
        check("wr_en",         wr_en,         e_wr[cyc]);
        check("wr_addr",       wr_addr,       e_wr[cyc] ? e_wa[cyc] : 8'd0);
        check("wr_data",       wr_data,       e_wr[cyc] ? e_wd[cyc] : 2'd0);
        check("change_enable", change_enable, e_ce[cyc]);
        check("turn",          turn,          e_turn[cyc]);
        check("busy",          busy,          e_busy[cyc]);
        check("reject",        reject,        e_rej[cyc]);
        check("move_count",    move_count,    exp_count);
        check("board_full",    board_full,    exp_count == CELLS);
        if (e_rdv[cyc]) check("rd_addr", rd_addr, e_ra[cyc]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #60000;
    $display("FAIL watchdog cycle=%0d got=running expected=done", cyc);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    @(negedge clk);
    while (cyc < busy_until) @(negedge clk);
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Issue a one-cycle place pulse at the current negedge.
  task automatic pulse(input int rx, input int ry, input int rc, input bit go);
    x         = 4'(rx);
    y         = 4'(ry);
    color     = 2'(rc);
    game_over = go;
    place     = 1'b1;
    model_request(cyc, rx, ry, rc, go);
    @(negedge clk);
    place = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int k;
  int col;

  initial begin
    for (int i = 0; i < 256; i++) mboard[i] = 2'b00;
    resetn  = 1'b0;
    ram_clr = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wr_en",  wr_en, 0);
    check("rst_turn",   turn, 0);
    check("rst_ce",     change_enable, 0);
    check("rst_busy",   busy, 0);
    check("rst_reject", reject, 0);
    check("rst_count",  move_count, 0);
    check("rst_full",   board_full, 0);
    check("rst_rdaddr", rd_addr, 0);
    check("rst_state",  dbg_state, 0);
    ram_clr = 1'b0;
    resetn  = 1'b1;
    chk_en  = 1'b1;

    // First move at (3,4), player0.
    wait_idle();
    k = cyc;
    pulse(3, 4, 1, 0);
    to_cycle(k + 3);
    check("t1_wr_en", wr_en, 1);
    check("t1_wr_addr", wr_addr, 63);
    check("t1_wr_data", wr_data, 1);
    to_cycle(k + 4);
    check("t1_ce_c4", change_enable, 1);
    check("t1_turn_c4", turn, 0);
    to_cycle(k + 5);
    check("t1_turn_c5", turn, 1);
    to_cycle(k + 6);
    check("t1_count", move_count, 1);
    check("t1_ram63", ram[63], 1);

    // Same cell, player1: occupied.
    wait_idle();
    k = cyc;
    pulse(3, 4, 2, 0);
    to_cycle(k + 3);
    check("t2_reject", reject, 1);
    check("t2_wr_en", wr_en, 0);
    to_cycle(k + 4);
    check("t2_count", move_count, 1);

    // Out-of-range column, bad colour, game over.
    wait_idle();
    pulse(15, 0, 1, 0);
    wait_idle();
    pulse(5, 5, 3, 0);
    wait_idle();
    k = cyc;
    pulse(6, 6, 1, 1);
    to_cycle(k + 3);
    check("t3_go_reject", reject, 1);
    wait_idle();
    game_over = 1'b0;
    check("t3_count", move_count, 1);
    check("t3_ram15", ram[15], 0);
    check("t3_ram80", ram[80], 0);
    check("t3_ram96", ram[96], 0);

    // Second place edge while busy (cycle 2) is dropped.
    wait_idle();
    pulse(7, 7, 2, 0);
    @(negedge clk);
    pulse(8, 8, 1, 0);
    wait_idle();
    check("t4_count", move_count, 2);
    check("t4_ram112", ram[112], 2);
    check("t4_ram128", ram[128], 0);

    // Fill the rest of the board back-to-back, alternating colour.
    col = 1;
    for (int a = 0; a < CELLS; a++) begin
      if (mboard[a] == 2'b00) begin
        wait_idle();
        pulse(a % SIDE, a / SIDE, col, 0);
        col = (col == 1) ? 2 : 1;
      end
    end
    wait_idle();
    check("t5_count", move_count, 225);
    check("t5_full", board_full, 1);
    check("t5_ram224", ram[224], mboard[224]);
    wait_idle();
    k = cyc;
    pulse(0, 0, 1, 0);
    to_cycle(k + 3);
    check("t5_226_reject", reject, 1);
    wait_idle();
    check("t5_count_sat", move_count, 225);

    // Reset during ARM: turn never issued.
    resetn  = 1'b0;
    ram_clr = 1'b1;
    model_reset(cyc);
    for (int i = 0; i < 256; i++) mboard[i] = 2'b00;
    @(negedge clk);
    ram_clr = 1'b0;
    resetn  = 1'b1;
    wait_idle();
    k = cyc;
    pulse(3, 4, 1, 0);
    to_cycle(k + 4);
    check("t6_ce_arm", change_enable, 1);
    resetn = 1'b0;
    #1;
    check("t6_async_ce", change_enable, 0);
    check("t6_async_turn", turn, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_count", move_count, 0);
    model_reset(cyc);
    to_cycle(k + 6);
    resetn = 1'b1;
    check("t6_state_idle", dbg_state, 0);
    check("t6_busy_idle", busy, 0);

    // Controller still works after the reset; (3,4) is now occupied.
    wait_idle();
    pulse(1, 1, 2, 0);
    wait_idle();
    check("t7_count", move_count, 1);
    check("t7_ram16", ram[16], 2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
